// File: rtl/bram_client_pkg.sv
// Shared constants and read-latency derivation for the BRAM client.
package bram_client_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PIPELINED  = 0;
    localparam int DEF_RSP_DEPTH  = 4;

    // Read latency of the attached BRAM: the output register adds one stage.
    function automatic int bram_lat(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/bram_client_if.sv
// Request/response bus plus BRAM port bundle; slave = client side, master = requester/BRAM side.
interface bram_client_if
    import bram_client_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_dout,
        output req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_din
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, bram_dout,
        input  req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, bram_addr, bram_din
    );

endinterface

// File: rtl/bram_client_rsp_fifo.sv
// First-word-fall-through response FIFO; capacity is guaranteed by the caller's credit counter.
module bram_client_rsp_fifo
    import bram_client_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_dout
);

    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W:0]        r_wr_ptr;
    logic [PTR_W:0]        r_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_do_pop = i_pop & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
    end

    assign o_valid = ~w_empty;
    assign o_dout  = r_mem[r_rd_ptr[PTR_W-1:0]];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/bram_client.sv
// BRAM read/write client: credit-limited request acceptance, read-tag pipeline and ordered responses.
module bram_client
    import bram_client_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PIPELINED  = DEF_PIPELINED,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    bram_client_if.slave  bus,
    output logic          busy
);

    localparam int                LAT   = bram_lat(PIPELINED);
    localparam int                OCC_W = $clog2(RSP_DEPTH + 1);
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(RSP_DEPTH);

    logic [OCC_W-1:0] r_occ;
    logic [LAT-1:0]   r_tag;
    logic [LAT-1:0]   w_tag_next;
    logic             w_accept;
    logic             w_acc_rd;
    logic             w_pop;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    assign bus.req_ready = rst_n && (r_occ < OCC_MAX);
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_acc_rd      = w_accept & ~bus.req_write;
    assign w_pop         = bus.rsp_valid & bus.rsp_ready;

    assign bus.bram_en   = w_accept;
    assign bus.bram_we   = bus.req_write;
    assign bus.bram_addr = bus.req_addr;
    assign bus.bram_din  = bus.req_wdata;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign w_tag_next[gi] = w_acc_rd;
            end else begin : g_body
                assign w_tag_next[gi] = r_tag[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
            r_tag <= '0;
        end else begin
            r_tag <= w_tag_next;
            if (w_acc_rd && !w_pop)
                r_occ <= r_occ + 1'b1;
            else if (!w_acc_rd && w_pop)
                r_occ <= r_occ - 1'b1;
        end
    end

    assign busy = (r_occ != '0);

    // Tag leaving the last stage marks the cycle the BRAM output belongs to a read.
    bram_client_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_tag[LAT-1]),
        .i_din   (bus.bram_dout),
        .i_pop   (w_pop),
        .o_valid (bus.rsp_valid),
        .o_dout  (bus.rsp_rdata)
    );

endmodule

// File: doc/bram_client.md
BRAM_CLIENT -- requirements
Module: bram_client

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-003 Parameter PIPELINED, default 0, SHALL set the attached BRAM's read latency: LAT = 1 when 0, LAT = 2 when 1.
REQ-004 Parameter RSP_DEPTH, default 4, SHALL set the response FIFO depth; legal values are powers of two, 2 or greater.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 CLK  in  1  rising-edge clock.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  request offered.
REQ-009 req_ready  out  1  request accepted when high with req_valid.
REQ-010 req_write  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_WIDTH  request address.
REQ-012 req_wdata  in  DATA_WIDTH  write data.
REQ-013 rsp_valid  out  1  read data available.
REQ-014 rsp_ready  in  1  consumer takes read data.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data, in request order.
REQ-016 bram_en  out  1  BRAM port enable.
REQ-017 bram_we  out  1  BRAM write enable.
REQ-018 bram_addr  out  ADDR_WIDTH  BRAM address.
REQ-019 bram_din  out  DATA_WIDTH  BRAM write data.
REQ-020 bram_dout  in  DATA_WIDTH  BRAM read data.
REQ-021 busy  out  1  high while any read is in flight or any response is buffered.

Function
REQ-022 Accept: a request SHALL be accepted in any cycle in which req_valid and req_ready are both high.
REQ-023 Issue: bram_en SHALL equal (req_valid & req_ready) combinationally; bram_we, bram_addr and bram_din SHALL pass through req_write, req_addr and req_wdata.
REQ-024 Occupancy counter occ (width clog2(RSP_DEPTH+1)) SHALL count in-flight reads plus buffered responses:
- +1 on an accepted read.
- -1 on a response handshake (rsp_valid & rsp_ready).
- Unchanged when both occur in the same cycle.
REQ-025 req_ready SHALL equal (occ < RSP_DEPTH) and SHALL NOT depend on req_valid or req_write; writes are therefore also stalled when occ = RSP_DEPTH.
REQ-026 Writes SHALL NOT change occ and SHALL NOT produce a response; the data the BRAM returns after a write SHALL be discarded.
REQ-027 In-flight tracking: a LAT-stage shift register SHALL carry a read-tag bit; bram_dout SHALL be pushed into the FIFO in the cycle in which the tag exits stage LAT.
REQ-028 Latency: a read accepted in cycle t SHALL present rsp_valid in cycle t+LAT+1; there is no bypass path.
REQ-029 The FIFO SHALL be first-word-fall-through: rsp_valid = not empty, and rsp_rdata = head entry, held stable while rsp_valid is high and rsp_ready is low.
REQ-030 The FIFO SHALL never overflow; the credit scheme guarantees a slot exists at every push. A push into a full FIFO SHALL be an assertion failure.
REQ-031 A push and a pop in the same cycle SHALL both take effect.
REQ-032 Throughput: with rsp_ready held high and RSP_DEPTH >= LAT+2, one read SHALL be accepted per cycle indefinitely.
REQ-033 Address arithmetic SHALL be pass-through only; no wrap handling is performed by this block.

Reset
REQ-034 While RST_N is low:
- req_ready = 0, bram_en = 0, rsp_valid = 0, busy = 0.
- occ = 0; tag shift register and FIFO pointers cleared.
REQ-035 Reset asserted mid-operation SHALL discard in-flight reads and buffered responses; BRAM contents are untouched.
REQ-036 req_ready SHALL rise in the first cycle after RST_N deasserts.

Structure
REQ-037 Package bram_client_pkg SHALL hold the LAT derivation function and default parameter constants.
REQ-038 The response FIFO SHALL be a sub-module, bram_client_rsp_fifo, parameterized by DATA_WIDTH and RSP_DEPTH.
REQ-039 The top level SHALL contain only the accept logic, occ counter, tag shift register and port wiring.

Verification
REQ-040 PIPELINED=0: write 0xDEADBEEF to addr 5, then read addr 5 -> rsp_rdata = 0xDEADBEEF with rsp_valid exactly 2 cycles after the read is accepted; no response for the write.
REQ-041 PIPELINED=1: 8 back-to-back reads of addrs 0..7, rsp_ready held high -> 8 in-order responses, first at accept+3, then one per cycle, req_ready never low.
REQ-042 rsp_ready held low, RSP_DEPTH=4: issue reads -> exactly 4 accepted, then req_ready = 0 and a pending write also stalls; raising rsp_ready for one cycle -> exactly one new request accepted.
REQ-043 Simultaneous push, pop and accept with occ=3 -> occ stays 3, data order preserved.
REQ-044 Assert RST_N low with 2 reads in flight and 2 buffered -> all outputs take their reset values asynchronously; after release, no stale responses appear and a fresh read returns the correct BRAM data.
